// File: rtl/key_evt_pkg.sv
// Event type codes and hold-tracker state encodings shared by the key event
// scheduler and the CPU-side event register block.
package key_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_DONE   = 2'd3
  } hold_state_e;

endpackage

// File: rtl/key_evt_rr_arb.sv
// Combinational round-robin arbiter: grants the first requesting key at or
// after the pointer, wrapping around NUM_KEYS.
module key_evt_rr_arb #(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = $clog2(NUM_KEYS)
) (
  input  logic [NUM_KEYS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  output logic [IDX_W-1:0]    gnt,
  output logic                any_gnt
);

  logic [IDX_W-1:0] cand;

  function automatic int wrap_idx(input int v);
    return (v >= NUM_KEYS) ? v - NUM_KEYS : v;
  endfunction

  always_comb begin
    gnt     = '0;
    any_gnt = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cand = IDX_W'(wrap_idx(int'(ptr) + k));
      if (!any_gnt && req[cand]) begin
        any_gnt = 1'b1;
        gnt     = cand;
      end
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Turns debounced active-low key levels into an ordered PRESS/RELEASE/LONG/REPEAT
// event stream on a valid/ready slot. REPEAT events exist only with KEY_EVT_REPEAT_EN.
module key_event_scheduler
  import key_evt_pkg::*;
#(
  parameter int NUM_KEYS    = 4,
  parameter int LONG_TIME   = 50_000_000,
  parameter int REPEAT_TIME = 10_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         click_n,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [$clog2(NUM_KEYS)-1:0] evt_key,
  output logic [1:0]                  evt_type,
  output logic [NUM_KEYS-1:0]         key_state,
  output logic                        overrun
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TIME - 1);
  localparam hold_state_e AFTER_LONG = ST_REPEAT;
`else
  localparam hold_state_e AFTER_LONG = ST_DONE;
`endif

  if ((longint'(LONG_TIME) - 1 >= (longint'(1) << CNT_W)) ||
      (longint'(REPEAT_TIME) - 1 >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("key_event_scheduler: CNT_W too narrow for LONG_TIME/REPEAT_TIME");
  end

  logic [NUM_KEYS-1:0] key_d, key_prev, press_edge, rel_edge;
  logic [NUM_KEYS-1:0] press_pend, rel_pend, req, gnt_press, gnt_rel;
  logic                hold_pend, hold_set, hold_take, key_take, load, any_gnt;
  logic [1:0]          hold_type, hold_set_type;
  logic [KW-1:0]       hold_key, rr_ptr, gnt, track, arm_key;
  logic [CNT_W-1:0]    timer;
  logic                timer_clr, track_rel;
  hold_state_e         state, state_nx;

  // Input register and edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_d    <= '0;
      key_prev <= '0;
    end else begin
      key_d    <= ~click_n;
      key_prev <= key_d;
    end
  end

  assign press_edge = key_d & ~key_prev;
  assign rel_edge   = ~key_d & key_prev;
  assign key_state  = key_d;
  assign track_rel  = rel_edge[track];

  always_comb begin
    arm_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_edge[i]) arm_key = KW'(i);
    end
  end

  // Hold tracker FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (|press_edge) state_nx = ST_HOLD;
      ST_HOLD:   if (track_rel) state_nx = ST_IDLE;
                 else if (timer == LONG_LAST) state_nx = AFTER_LONG;
      ST_REPEAT: if (track_rel) state_nx = ST_IDLE;
      ST_DONE:   if (track_rel) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    timer_clr     = 1'b1;
    hold_set      = 1'b0;
    hold_set_type = EVT_LONG;
    case (state)
      ST_HOLD: begin
        timer_clr = track_rel || (timer == LONG_LAST);
        hold_set  = !track_rel && (timer == LONG_LAST);
      end
`ifdef KEY_EVT_REPEAT_EN
      ST_REPEAT: begin
        timer_clr     = track_rel || (timer == REP_LAST);
        hold_set      = !track_rel && (timer == REP_LAST);
        hold_set_type = EVT_REPEAT;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      track <= '0;
    end else begin
      timer <= timer_clr ? '0 : timer + 1'b1;
      if (state == ST_IDLE && |press_edge) track <= arm_key;
    end
  end

  // Pending events and arbitration; hold events outrank key events
  assign req       = press_pend | rel_pend;
  assign load      = !evt_valid || evt_ready;
  assign hold_take = load && hold_pend;
  assign key_take  = load && !hold_pend && any_gnt;

  key_evt_rr_arb #(.NUM_KEYS(NUM_KEYS), .IDX_W(KW)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .any_gnt (any_gnt)
  );

  always_comb begin
    gnt_press = '0;
    gnt_rel   = '0;
    if (key_take) begin
      if (press_pend[gnt]) gnt_press[gnt] = 1'b1;
      else                 gnt_rel[gnt]   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pend <= '0;
      rel_pend   <= '0;
      hold_pend  <= 1'b0;
      hold_type  <= EVT_LONG;
      hold_key   <= '0;
      overrun    <= 1'b0;
    end else begin
      press_pend <= (press_pend & ~gnt_press) | (press_edge & ~press_pend);
      rel_pend   <= (rel_pend & ~gnt_rel) | (rel_edge & ~rel_pend);
      hold_pend  <= (hold_pend & ~hold_take) | (hold_set & ~hold_pend);
      if (hold_set && !hold_pend) begin
        hold_type <= hold_set_type;
        hold_key  <= track;
      end
      overrun <= (|(press_edge & press_pend)) | (|(rel_edge & rel_pend)) |
                 (hold_set & hold_pend);
    end
  end

  // Output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_type  <= EVT_PRESS;
      rr_ptr    <= '0;
    end else if (hold_take) begin
      evt_valid <= 1'b1;
      evt_key   <= hold_key;
      evt_type  <= hold_type;
    end else if (key_take) begin
      evt_valid <= 1'b1;
      evt_key   <= gnt;
      evt_type  <= press_pend[gnt] ? EVT_PRESS : EVT_RELEASE;
      rr_ptr    <= (gnt == KW'(NUM_KEYS - 1)) ? '0 : gnt + 1'b1;
    end else if (load) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
